// File: rtl/branch_predictor_tables.sv
// -----------------------------------------------------------------------------
// branch_predictor_tables
//
// Gshare prediction state for the fetch path: global branch history register
// (BHR), a pattern table of 2-bit saturating counters and a direct-mapped BTB.
// FE reads the tables combinationally every cycle; AGEX writes them once per
// resolved branch/jump. Branch and mispredict counters are kept for debug.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   pt_rd_idx       FE pattern-table index (PC[9:2] ^ BHR, formed in FE)
//   btb_rd_idx      FE BTB index
//   pt_rd_val       counter at pt_rd_idx
//   btb_rd_tag      tag at btb_rd_idx, all-ones when the entry is invalid
//   btb_rd_target   target at btb_rd_idx, zero when the entry is invalid
//   btb_rd_valid    valid bit at btb_rd_idx
//   bhr_val         current global history
//   upd_*           one resolved control-flow instruction from AGEX
//   br_count        number of conditional-branch updates (saturating)
//   mispred_count   number of mispredicted updates (saturating)
// -----------------------------------------------------------------------------
module branch_predictor_tables #(
    parameter int         DBITS        = 32,
    parameter int         BHR_BITS     = 8,
    parameter int         PT_IDX_BITS  = 8,
    parameter int         BTB_IDX_BITS = 4,
    parameter int         TAG_BITS     = 26,
    parameter logic [1:0] PT_INIT      = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PT_IDX_BITS-1:0]  pt_rd_idx,
    input  logic [BTB_IDX_BITS-1:0] btb_rd_idx,
    output logic [1:0]              pt_rd_val,
    output logic [TAG_BITS-1:0]     btb_rd_tag,
    output logic [DBITS-1:0]        btb_rd_target,
    output logic                    btb_rd_valid,
    output logic [BHR_BITS-1:0]     bhr_val,
    input  logic                    upd_valid,
    input  logic                    upd_is_br,
    input  logic                    upd_taken,
    input  logic                    upd_mispred,
    input  logic [PT_IDX_BITS-1:0]  upd_pt_idx,
    input  logic [BTB_IDX_BITS-1:0] upd_btb_idx,
    input  logic [TAG_BITS-1:0]     upd_tag,
    input  logic [DBITS-1:0]        upd_target,
    output logic [DBITS-1:0]        br_count,
    output logic [DBITS-1:0]        mispred_count
);

    localparam int PT_ENTRIES  = 32'd1 << PT_IDX_BITS;
    localparam int BTB_ENTRIES = 32'd1 << BTB_IDX_BITS;

    // Next value of a 2-bit saturating direction counter.
    function automatic logic [1:0] pt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        case ({taken, cnt})
            3'b111:  res = 2'b11;
            3'b000:  res = 2'b00;
            3'b100,
            3'b101,
            3'b110:  res = cnt + 2'b01;
            3'b001,
            3'b010,
            3'b011:  res = cnt - 2'b01;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [DBITS-1:0] sat_inc(input logic [DBITS-1:0] v);
        logic [DBITS-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + {{(DBITS-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [1:0]              pt_r         [PT_ENTRIES];
    logic [BTB_ENTRIES-1:0]  btb_valid_r;
    logic [TAG_BITS-1:0]     btb_tag_r    [BTB_ENTRIES];
    logic [DBITS-1:0]        btb_target_r [BTB_ENTRIES];
    logic [BHR_BITS-1:0]     bhr_r;
    logic [DBITS-1:0]        br_count_r;
    logic [DBITS-1:0]        mispred_count_r;

    logic                    upd_br_s;
    logic                    btb_wr_s;

    // Conditional branches train PT/BHR; jumps and taken branches fill the BTB.
    assign upd_br_s = upd_valid & upd_is_br;
    assign btb_wr_s = upd_valid & (~upd_is_br | upd_taken);

    // Pattern table: every entry returns to PT_INIT on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PT_ENTRIES; i++) begin
                pt_r[i] <= PT_INIT;
            end
        end else if (upd_br_s) begin
            pt_r[upd_pt_idx] <= pt_next(pt_r[upd_pt_idx], upd_taken);
        end
    end

    // Global history shifts in the resolved direction of each conditional branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bhr_r <= {BHR_BITS{1'b0}};
        end else if (upd_br_s) begin
            bhr_r <= {bhr_r[BHR_BITS-2:0], upd_taken};
        end
    end

    // BTB valid bits; a write simply replaces whatever was at that index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid_r <= {BTB_ENTRIES{1'b0}};
        end else if (btb_wr_s) begin
            btb_valid_r[upd_btb_idx] <= 1'b1;
        end
    end

    // BTB tag/target payload; contents are masked by the valid bit so need no reset.
    always_ff @(posedge clk) begin
        if (btb_wr_s) begin
            btb_tag_r[upd_btb_idx]    <= upd_tag;
            btb_target_r[upd_btb_idx] <= upd_target;
        end
    end

    // Debug statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count_r      <= {DBITS{1'b0}};
            mispred_count_r <= {DBITS{1'b0}};
        end else begin
            if (upd_br_s) begin
                br_count_r <= sat_inc(br_count_r);
            end
            if (upd_valid && upd_mispred) begin
                mispred_count_r <= sat_inc(mispred_count_r);
            end
        end
    end

    // Zero-latency read port. An invalid entry reports an all-ones tag, which
    // lies outside IMEM, so FE's tag compare can never hit on stale contents.
    always_comb begin
        pt_rd_val     = pt_r[pt_rd_idx];
        btb_rd_valid  = btb_valid_r[btb_rd_idx];
        btb_rd_tag    = {TAG_BITS{1'b1}};
        btb_rd_target = {DBITS{1'b0}};
        if (btb_valid_r[btb_rd_idx]) begin
            btb_rd_tag    = btb_tag_r[btb_rd_idx];
            btb_rd_target = btb_target_r[btb_rd_idx];
        end else begin
            btb_rd_tag    = {TAG_BITS{1'b1}};
            btb_rd_target = {DBITS{1'b0}};
        end
    end

    assign bhr_val       = bhr_r;
    assign br_count      = br_count_r;
    assign mispred_count = mispred_count_r;

endmodule

// File: tb/tb_branch_predictor_tables.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_tables
//
// Directed, table-driven bench. Each record drives the read indices and one
// update; outputs are checked just after the falling edge, i.e. before the
// update is clocked in, so each row's expectations describe the state left by
// the earlier rows. Hand-written sequences cover reset and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_branch_predictor_tables;

    logic        clk;
    logic        reset;
    logic [7:0]  pt_rd_idx;
    logic [3:0]  btb_rd_idx;
    logic [1:0]  pt_rd_val;
    logic [25:0] btb_rd_tag;
    logic [31:0] btb_rd_target;
    logic        btb_rd_valid;
    logic [7:0]  bhr_val;
    logic        upd_valid;
    logic        upd_is_br;
    logic        upd_taken;
    logic        upd_mispred;
    logic [7:0]  upd_pt_idx;
    logic [3:0]  upd_btb_idx;
    logic [25:0] upd_tag;
    logic [31:0] upd_target;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int checks;
    int failures;

    branch_predictor_tables dut (
        .clk           (clk),
        .reset         (reset),
        .pt_rd_idx     (pt_rd_idx),
        .btb_rd_idx    (btb_rd_idx),
        .pt_rd_val     (pt_rd_val),
        .btb_rd_tag    (btb_rd_tag),
        .btb_rd_target (btb_rd_target),
        .btb_rd_valid  (btb_rd_valid),
        .bhr_val       (bhr_val),
        .upd_valid     (upd_valid),
        .upd_is_br     (upd_is_br),
        .upd_taken     (upd_taken),
        .upd_mispred   (upd_mispred),
        .upd_pt_idx    (upd_pt_idx),
        .upd_btb_idx   (upd_btb_idx),
        .upd_tag       (upd_tag),
        .upd_target    (upd_target),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  rd_pt;
        logic [3:0]  rd_btb;
        logic        uv;
        logic        ubr;
        logic        utk;
        logic        ump;
        logic [7:0]  upt;
        logic [3:0]  ubtb;
        logic [25:0] utag;
        logic [31:0] utgt;
        logic [1:0]  e_pt;
        logic        e_vld;
        logic [25:0] e_tag;
        logic [31:0] e_tgt;
        logic [7:0]  e_bhr;
        logic [31:0] e_br;
        logic [31:0] e_mp;
    } vec_t;

    localparam logic [25:0] INV_TAG = 26'h3FF_FFFF;
    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic [7:0] rd_pt, input logic [3:0] rd_btb,
        input logic uv, input logic ubr, input logic utk, input logic ump,
        input logic [7:0] upt, input logic [3:0] ubtb,
        input logic [25:0] utag, input logic [31:0] utgt,
        input logic [1:0] e_pt, input logic e_vld, input logic [25:0] e_tag,
        input logic [31:0] e_tgt, input logic [7:0] e_bhr,
        input logic [31:0] e_br, input logic [31:0] e_mp);
        vec_t v;
        v.rd_pt = rd_pt; v.rd_btb = rd_btb;
        v.uv = uv; v.ubr = ubr; v.utk = utk; v.ump = ump;
        v.upt = upt; v.ubtb = ubtb; v.utag = utag; v.utgt = utgt;
        v.e_pt = e_pt; v.e_vld = e_vld; v.e_tag = e_tag; v.e_tgt = e_tgt;
        v.e_bhr = e_bhr; v.e_br = e_br; v.e_mp = e_mp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_pt, input logic e_vld,
                           input logic [25:0] e_tag, input logic [31:0] e_tgt,
                           input logic [7:0] e_bhr, input logic [31:0] e_br,
                           input logic [31:0] e_mp);
        chk({tag, " pt_rd_val"},     {30'd0, pt_rd_val},     {30'd0, e_pt});
        chk({tag, " btb_rd_valid"},  {31'd0, btb_rd_valid},  {31'd0, e_vld});
        chk({tag, " btb_rd_tag"},    {6'd0, btb_rd_tag},     {6'd0, e_tag});
        chk({tag, " btb_rd_target"}, btb_rd_target,          e_tgt);
        chk({tag, " bhr_val"},       {24'd0, bhr_val},       {24'd0, e_bhr});
        chk({tag, " br_count"},      br_count,               e_br);
        chk({tag, " mispred_count"}, mispred_count,          e_mp);
    endtask

    task automatic idle_upd();
        upd_valid = 1'b0; upd_is_br = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
        upd_pt_idx = 8'h00; upd_btb_idx = 4'h0; upd_tag = 26'h0; upd_target = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        pt_rd_idx  = 8'h00;
        btb_rd_idx = 4'h0;
        idle_upd();

        // Row order: rd_pt rd_btb | valid is_br taken mispred pt_idx btb_idx tag target
        //            | exp pt valid tag target bhr br_count mispred_count
        // 3x taken branch on PT[0x10]: 01->10->11, bhr 00->01->03->07.
        vecs[0]  = mk(8'h10, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'h1, 26'h2, 32'h200,
                      2'b01, 1'b0, INV_TAG, 32'h0,   8'h00, 32'd0, 32'd0);
        vecs[1]  = mk(8'h10, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'h1, 26'h2, 32'h200,
                      2'b10, 1'b1, 26'h2,   32'h200, 8'h01, 32'd1, 32'd0);
        vecs[2]  = mk(8'h10, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'h1, 26'h2, 32'h200,
                      2'b11, 1'b1, 26'h2,   32'h200, 8'h03, 32'd2, 32'd0);
        // Taken branch into BTB[5]: same-cycle read still sees the invalid entry;
        // PT[0x10] saturates at 11.
        vecs[3]  = mk(8'h10, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'h5, 26'h1, 32'h100,
                      2'b11, 1'b0, INV_TAG, 32'h0,   8'h07, 32'd3, 32'd0);
        // Not-taken branch on PT[0x20]/BTB[6]; BTB[5] now visible.
        vecs[4]  = mk(8'h10, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 4'h6, 26'h3, 32'h300,
                      2'b11, 1'b1, 26'h1,   32'h100, 8'h0F, 32'd4, 32'd0);
        vecs[5]  = mk(8'h20, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 4'h6, 26'h3, 32'h300,
                      2'b00, 1'b0, INV_TAG, 32'h0,   8'h1E, 32'd5, 32'd0);
        // Jump with mispredict (taken input ignored): BTB[7] written, PT/BHR/br untouched.
        vecs[6]  = mk(8'h20, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 4'h7, 26'h4, 32'h40,
                      2'b00, 1'b0, INV_TAG, 32'h0,   8'h3C, 32'd6, 32'd0);
        // upd_valid=0 with busy side fields: nothing may change.
        vecs[7]  = mk(8'h30, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30, 4'h8, 26'h9, 32'h900,
                      2'b01, 1'b1, 26'h4,   32'h40,  8'h3C, 32'd6, 32'd1);
        vecs[8]  = mk(8'h30, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 26'h0, 32'h0,
                      2'b01, 1'b0, INV_TAG, 32'h0,   8'h3C, 32'd6, 32'd1);
        // Aliasing: new taken branch evicts BTB[5], mispredicted.
        vecs[9]  = mk(8'h40, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 4'h5, 26'h7, 32'h700,
                      2'b01, 1'b1, 26'h1,   32'h100, 8'h3C, 32'd6, 32'd1);
        vecs[10] = mk(8'h40, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 26'h0, 32'h0,
                      2'b10, 1'b1, 26'h7,   32'h700, 8'h79, 32'd7, 32'd2);

        // Reset state: sweep PT corners and every BTB index.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pt_rd_idx  = (i % 2 == 0) ? 8'h00 : 8'hFF;
            btb_rd_idx = i[3:0];
            #1;
            chk_all($sformatf("reset idx%0d", i), 2'b01, 1'b0, INV_TAG, 32'h0, 8'h00, 32'd0, 32'd0);
            @(negedge clk);
        end

        // Directed vectors.
        for (int i = 0; i < NVEC; i++) begin
            pt_rd_idx   = vecs[i].rd_pt;
            btb_rd_idx  = vecs[i].rd_btb;
            upd_valid   = vecs[i].uv;
            upd_is_br   = vecs[i].ubr;
            upd_taken   = vecs[i].utk;
            upd_mispred = vecs[i].ump;
            upd_pt_idx  = vecs[i].upt;
            upd_btb_idx = vecs[i].ubtb;
            upd_tag     = vecs[i].utag;
            upd_target  = vecs[i].utgt;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pt, vecs[i].e_vld, vecs[i].e_tag,
                    vecs[i].e_tgt, vecs[i].e_bhr, vecs[i].e_br, vecs[i].e_mp);
            @(negedge clk);
        end

        // BTB[7] from the jump is still intact.
        pt_rd_idx  = 8'h20;
        btb_rd_idx = 4'h7;
        #1;
        chk_all("jump entry", 2'b00, 1'b1, 26'h4, 32'h40, 8'h79, 32'd7, 32'd2);

        // Mid-stream async reset, asserted between edges with an update pending.
        @(negedge clk);
        pt_rd_idx   = 8'h40;
        btb_rd_idx  = 4'h5;
        upd_valid   = 1'b1; upd_is_br = 1'b1; upd_taken = 1'b1; upd_mispred = 1'b1;
        upd_pt_idx  = 8'h40; upd_btb_idx = 4'h5; upd_tag = 26'h8; upd_target = 32'h800;
        #1;
        reset = 1'b1;
        #1;
        chk_all("midreset async", 2'b01, 1'b0, INV_TAG, 32'h0, 8'h00, 32'd0, 32'd0);
        btb_rd_idx = 4'h7;
        pt_rd_idx  = 8'h10;
        #1;
        chk_all("midreset idx7", 2'b01, 1'b0, INV_TAG, 32'h0, 8'h00, 32'd0, 32'd0);
        // Hold reset across a rising edge with the update still asserted.
        @(negedge clk);
        reset = 1'b0;
        idle_upd();
        btb_rd_idx = 4'h5;
        pt_rd_idx  = 8'h40;
        #1;
        chk_all("after reset", 2'b01, 1'b0, INV_TAG, 32'h0, 8'h00, 32'd0, 32'd0);

        // One clean update after reset release works again.
        upd_valid = 1'b1; upd_is_br = 1'b1; upd_taken = 1'b1;
        upd_pt_idx = 8'h40; upd_btb_idx = 4'h5; upd_tag = 26'hA; upd_target = 32'hA00;
        @(negedge clk);
        idle_upd();
        #1;
        chk_all("post reset upd", 2'b10, 1'b1, 26'hA, 32'hA00, 8'h01, 32'd1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
